// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sender sequencer: FSM state encoding and frame geometry.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_e;

    localparam int BITS_PER_FRAME = 8;
    localparam int SHIFT_PULSES   = 7;
    localparam int TMR_W          = 8;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: CLK_DIV-cycle half-period down-counter, idles low while disabled.
// The strobes flag the CLK edge at which SCLK is about to rise or fall.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tc;

    assign tc = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = RELOAD;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = RELOAD;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            cnt_q  <= RELOAD;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign rise_stb_o = tc && !sclk_q;
    assign fall_stb_o = tc &&  sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Sequencer for an 8-bit SPI sender shift register: handshake, CS_N framing, SCLK and load/shift control.
// Optional receive path (MISO sampling into RX_DATA) is built when SPI_CTRL_RX_EN is defined.
//   state | meaning
//   IDLE  | ready for a byte, CS_N high
//   SETUP | CS_N low for CS_SETUP cycles (>=1), sender in load mode
//   LOAD  | one SCLK period, rising edge loads the sender
//   SHIFT | seven SCLK periods shifting the remaining bits out
//   HOLD  | CS_HOLD cycles of CS_N low, then one cycle of CS_N high with DONE
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                      clk_i,
    input  logic                      clr_n_i,
    input  logic [BITS_PER_FRAME-1:0] tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      sclk_o,
    output logic                      cs_n_o,
    output logic [BITS_PER_FRAME-1:0] s_data_o,
    output logic                      s_write_o,
    output logic                      s_te_o,
    output logic                      s_clr_o,
    input  logic                      s_empty_i,
    input  logic                      s_full_i
`ifdef SPI_CTRL_RX_EN
    ,
    input  logic                      miso_i,
    output logic [BITS_PER_FRAME-1:0] rx_data_o,
    output logic                      rx_valid_o
`endif
);

    localparam int BCW = $clog2(BITS_PER_FRAME);

    state_e                    state_q, state_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_FRAME-1:0] s_data_q, s_data_d;
    logic                      err_q, err_d;
    logic                      cs_n_q, cs_n_d;
    logic                      done_q, done_d;
    logic                      clr_q;
    logic                      sclk_en, rise_stb, fall_stb, accept;

    assign sclk_en    = (state_q == LOAD) || (state_q == SHIFT);
    assign tx_ready_o = (state_q == IDLE) && !clr_q;
    assign accept     = tx_ready_o && tx_valid_i;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk_i      (clk_i),
        .clr_n_i    (clr_n_i),
        .en_i       (sclk_en),
        .sclk_o     (sclk_o),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        s_data_d  = s_data_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    s_data_d = tx_data_i;
                    tmr_d    = TMR_W'(CS_SETUP - 1);
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (tmr_q == '0) state_d = LOAD;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            LOAD: begin
                if (fall_stb) begin
                    if (!s_full_i) err_d = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (rise_stb) begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end else if (fall_stb && (bit_cnt_q == BCW'(SHIFT_PULSES))) begin
                    if (!s_empty_i) err_d = 1'b1;
                    tmr_d   = TMR_W'(CS_HOLD);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (tmr_q == '0) state_d = IDLE;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            default: state_d = IDLE;
        endcase
        // CS_N and DONE are registered from the next state so CS_N never glitches.
        done_d = (state_d == HOLD) && (tmr_d == '0);
        cs_n_d = (state_d == IDLE) || done_d;
    end

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            s_data_q  <= '0;
            err_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
            clr_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            s_data_q  <= s_data_d;
            err_q     <= err_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
            clr_q     <= 1'b0;
        end
    end

    assign done_o    = done_q;
    assign err_o     = err_q;
    assign cs_n_o    = cs_n_q;
    assign s_data_o  = s_data_q;
    assign s_clr_o   = clr_q;
    assign s_write_o = (state_q == SETUP) || (state_q == LOAD);
    assign s_te_o    = (state_q == SHIFT);

`ifdef SPI_CTRL_RX_EN
    logic [BITS_PER_FRAME-1:0] rx_sh_q, rx_sh_d, rx_data_q;
    logic                      rx_valid_q;

    assign rx_sh_d = fall_stb ? {rx_sh_q[BITS_PER_FRAME-2:0], miso_i} : rx_sh_q;

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= done_d;
            if (done_d) rx_data_q <= rx_sh_d;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1), each with a behavioural sender
// shift register clocked by SCLK, and a line monitor that reconstructs the frame seen by a slave.
module tb_spi_master_ctrl;

    localparam int DIV0 = 4;
    localparam int DIV1 = 1;
    localparam int CSS  = 2;
    localparam int CSH  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            clr_n;
    logic [1:0]      tx_valid, tx_ready, done, err, sclk, cs_n, s_write, s_te, s_clr;
    logic [1:0]      s_empty, s_full, mosi, fault_empty;
    logic [1:0][7:0] tx_data, s_data;
`ifdef SPI_CTRL_RX_EN
    logic [1:0]      rx_valid;
    logic [1:0][7:0] rx_data;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : gen_ch
        spi_master_ctrl #(
            .CLK_DIV  ((g == 0) ? DIV0 : DIV1),
            .CS_SETUP (CSS),
            .CS_HOLD  (CSH)
        ) u_dut (
            .clk_i      (clk),
            .clr_n_i    (clr_n),
            .tx_data_i  (tx_data[g]),
            .tx_valid_i (tx_valid[g]),
            .tx_ready_o (tx_ready[g]),
            .done_o     (done[g]),
            .err_o      (err[g]),
            .sclk_o     (sclk[g]),
            .cs_n_o     (cs_n[g]),
            .s_data_o   (s_data[g]),
            .s_write_o  (s_write[g]),
            .s_te_o     (s_te[g]),
            .s_clr_o    (s_clr[g]),
            .s_empty_i  (s_empty[g]),
            .s_full_i   (s_full[g])
`ifdef SPI_CTRL_RX_EN
            ,
            .miso_i     (mosi[g]),
            .rx_data_o  (rx_data[g]),
            .rx_valid_o (rx_valid[g])
`endif
        );

        // Sender: full right after a load, empty once only the last bit is left on MOSI.
        logic [7:0] sh  = 8'h00;
        int         cnt = 0;
        always @(posedge sclk[g] or posedge s_clr[g]) begin
            if (s_clr[g]) begin
                sh  <= 8'h00;
                cnt <= 0;
            end else if (s_write[g]) begin
                sh  <= s_data[g];
                cnt <= 8;
            end else if (s_te[g] && cnt > 0) begin
                sh  <= {sh[6:0], 1'b0};
                cnt <= cnt - 1;
            end
        end
        assign mosi[g]    = sh[7];
        assign s_full[g]  = (cnt == 8);
        assign s_empty[g] = (cnt == 1) && !fault_empty[g];
    end

    function automatic int div_of(input int g);
        return (g == 0) ? DIV0 : DIV1;
    endfunction

    // Line monitor: cumulative counters, sampled mid-cycle.
    int         m_rise[2]   = '{0, 0};
    int         m_fall[2]   = '{0, 0};
    int         m_per[2]    = '{0, 0};
    int         m_unst[2]   = '{0, 0};
    int         m_cs[2]     = '{0, 0};
    int         m_sclkcs[2] = '{0, 0};
    int         m_done[2]   = '{0, 0};
    int         m_rxv[2]    = '{0, 0};
    int         hi_run[2]   = '{0, 0};
    logic [7:0] m_bits[2]   = '{8'h00, 8'h00};
    logic       p_sclk[2]   = '{1'b0, 1'b0};
    logic       p_mosi[2]   = '{1'b0, 1'b0};
    logic       p_cs[2]     = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            p_sclk[g] <= sclk[g];
            p_mosi[g] <= mosi[g];
            p_cs[g]   <= cs_n[g];
            hi_run[g] <= sclk[g] ? hi_run[g] + 1 : 0;
            if (sclk[g] && !p_sclk[g]) m_rise[g] <= m_rise[g] + 1;
            if (!sclk[g] && p_sclk[g]) begin
                m_fall[g] <= m_fall[g] + 1;
                m_bits[g] <= {m_bits[g][6:0], p_mosi[g]};
                if (hi_run[g] != div_of(g)) m_per[g] <= m_per[g] + 1;
            end
            if (sclk[g] && p_sclk[g] && (mosi[g] != p_mosi[g])) m_unst[g] <= m_unst[g] + 1;
            if (cs_n[g] != p_cs[g]) m_cs[g] <= m_cs[g] + 1;
            if (sclk[g] && cs_n[g]) m_sclkcs[g] <= m_sclkcs[g] + 1;
            if (done[g]) m_done[g] <= m_done[g] + 1;
`ifdef SPI_CTRL_RX_EN
            if (rx_valid[g]) m_rxv[g] <= m_rxv[g] + 1;
`endif
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int c0[2], c_done[2];
    int s_rise[2], s_fall[2], s_per[2], s_unst[2], s_cs[2], s_sclkcs[2], s_rxv[2];

    task automatic start_frame(input int g, input logic [7:0] d, input bit keep, input logic [7:0] nd);
        int n = 0;
        while (!tx_ready[g] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ch%0d_ready", g), int'(tx_ready[g]), 1);
        s_rise[g]   = m_rise[g];
        s_fall[g]   = m_fall[g];
        s_per[g]    = m_per[g];
        s_unst[g]   = m_unst[g];
        s_cs[g]     = m_cs[g];
        s_sclkcs[g] = m_sclkcs[g];
        s_rxv[g]    = m_rxv[g];
        tx_data[g]  = d;
        tx_valid[g] = 1'b1;
        c0[g]       = cyc;
        @(negedge clk);
        if (keep) begin
            tx_data[g] = nd;
        end else begin
            tx_valid[g] = 1'b0;
            tx_data[g]  = 8'($urandom);
        end
    endtask

    task automatic finish_frame(input int g, input logic [7:0] d, input bit exp_err);
        int n   = 0;
        int rdy = 0;
        while (!done[g] && n < 400) begin
            if (tx_ready[g]) rdy++;
            @(negedge clk);
            n++;
        end
        c_done[g] = cyc;
        chk($sformatf("ch%0d_latency", g), cyc - c0[g], CSS + 16 * div_of(g) + CSH + 1);
        chk($sformatf("ch%0d_ready_low", g), rdy, 0);
        chk($sformatf("ch%0d_err", g), int'(err[g]), int'(exp_err));
        chk($sformatf("ch%0d_cs_at_done", g), int'(cs_n[g]), 1);
`ifdef SPI_CTRL_RX_EN
        chk($sformatf("ch%0d_rx_valid", g), int'(rx_valid[g]), 1);
        chk($sformatf("ch%0d_rx_data", g), int'(rx_data[g]), int'(d));
`endif
        @(negedge clk);
        chk($sformatf("ch%0d_done_width", g), int'(done[g]), 0);
        chk($sformatf("ch%0d_rises", g), m_rise[g] - s_rise[g], 8);
        chk($sformatf("ch%0d_falls", g), m_fall[g] - s_fall[g], 8);
        chk($sformatf("ch%0d_bits", g), int'(m_bits[g]), int'(d));
        chk($sformatf("ch%0d_half_period", g), m_per[g] - s_per[g], 0);
        chk($sformatf("ch%0d_mosi_stable", g), m_unst[g] - s_unst[g], 0);
        chk($sformatf("ch%0d_cs_edges", g), m_cs[g] - s_cs[g], 2);
        chk($sformatf("ch%0d_sclk_cs_high", g), m_sclkcs[g] - s_sclkcs[g], 0);
`ifdef SPI_CTRL_RX_EN
        chk($sformatf("ch%0d_rx_pulses", g), m_rxv[g] - s_rxv[g], 1);
`endif
    endtask

    task automatic send(input int g, input logic [7:0] d, input bit exp_err);
        start_frame(g, d, 1'b0, 8'h00);
        finish_frame(g, d, exp_err);
    endtask

    initial begin
        int n0;
        clr_n       = 1'b0;
        tx_valid    = 2'b00;
        tx_data     = '0;
        fault_empty = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", int'(cs_n), 3);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_s_clr", int'(s_clr), 3);
        chk("rst_ready", int'(tx_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_s_write", int'(s_write), 0);
        chk("rst_s_te", int'(s_te), 0);
        chk("rst_s_data", int'(s_data), 0);
        clr_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_clr", int'(s_clr), 0);
        chk("post_rst_ready", int'(tx_ready), 3);

        // Directed frames
        send(0, 8'hA5, 1'b0);
        send(0, 8'h5A, 1'b0);
        send(1, 8'hFF, 1'b0);
        send(1, 8'h00, 1'b0);

        // VALID held: second byte accepted the cycle after the first DONE
        start_frame(0, 8'h3C, 1'b1, 8'hC3);
        finish_frame(0, 8'h3C, 1'b0);
        chk("hs_ready_after_done", int'(tx_ready[0]), 1);
        chk("hs_gap", cyc - c_done[0], 1);
        start_frame(0, 8'hC3, 1'b0, 8'h00);
        finish_frame(0, 8'hC3, 1'b0);

        // Sender never reports EMPTY: ERR set and sticky across a clean frame
        fault_empty[0] = 1'b1;
        send(0, 8'($urandom), 1'b1);
        fault_empty[0] = 1'b0;
        send(0, 8'($urandom), 1'b1);
        chk("err_sticky", int'(err[0]), 1);

        // Reset in the middle of SHIFT
        start_frame(0, 8'($urandom), 1'b0, 8'h00);
        repeat (30) @(negedge clk);
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_cs_n", int'(cs_n[0]), 1);
        chk("mid_rst_sclk", int'(sclk[0]), 0);
        chk("mid_rst_s_clr", int'(s_clr[0]), 1);
        chk("mid_rst_err", int'(err[0]), 0);
        chk("mid_rst_done", int'(done[0]), 0);
        clr_n = 1'b1;
        n0 = m_done[0];
        repeat (100) @(negedge clk);
        chk("mid_rst_no_done", m_done[0] - n0, 0);
        chk("mid_rst_cs_idle", int'(cs_n[0]), 1);

        // Random traffic on both channels
        for (int i = 0; i < 10; i++) begin
            int         g;
            logic [7:0] d;
            g = int'($urandom_range(0, 1));
            d = 8'($urandom);
            send(g, d, 1'b0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
